// File: rtl/fill_responder.sv
// fill_responder: main-memory responder below the I-cache and D-cache.
// Serves block fills for either cache and single-word D-cache write-throughs.
// The I-cache has fixed priority. Storage is an internal word array behind a
// LATENCY-deep read pipeline, and fill data streams back one word per cycle.
// Optional build macro: FILL_RESPONDER_CRIT_WORD_EN. When it is defined, a
// fill returns the requested word first and then wraps within the block.
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   i_req, i_addr              I-cache fill request and byte address
//   d_req, d_wr, d_addr,       D-cache request; d_wr=1 is a single-word write,
//   d_wdata                    d_wr=0 is a block fill
//   grant_i, grant_d, busy     transaction owner and activity
//   rdata, rvalid, rword,      returned fill word, its offset in the block,
//   rdone                      and the last-word marker
//   wr_ack                     one-cycle pulse when a write commits
module fill_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 8,
  localparam int OFF_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              grant_i,
  output logic              grant_d,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [OFF_W-1:0]  rword,
  output logic              rdone,
  output logic              wr_ack
);

  localparam int WIDX_W = ADDR_W - 1;           // word index width
  localparam int BLK_W  = WIDX_W - OFF_W;       // block index width
  localparam int DEPTH  = 1 << WIDX_W;
  localparam int CNT_MAX = (BLOCK_WORDS > LATENCY) ? BLOCK_WORDS : LATENCY;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_i_q, is_i_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;

  logic               issue;
  logic [OFF_W-1:0]   issue_off;
  logic               issue_last;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               pipe_vld_q  [LATENCY];
  logic [DATA_W-1:0]  pipe_dat_q  [LATENCY];
  logic [OFF_W-1:0]   pipe_off_q  [LATENCY];
  logic               pipe_last_q [LATENCY];

  // Byte-address bit 0 carries no information for a word-addressed array.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{i_addr[0], d_addr[0]};

`ifdef FILL_RESPONDER_CRIT_WORD_EN
  // Critical word first: start at the requested offset and wrap in the block.
  assign issue_off = off_q + cnt_q[OFF_W-1:0];
`else
  assign issue_off = cnt_q[OFF_W-1:0];
`endif
  assign issue_last = (cnt_q == CNT_W'(BLOCK_WORDS - 1));

  // The pipeline exit drives the outputs. Data and offset are masked so that
  // the outputs read as zero whenever no word is being returned.
  assign rvalid  = pipe_vld_q[LATENCY-1];
  assign rdata   = rvalid ? pipe_dat_q[LATENCY-1] : '0;
  assign rword   = rvalid ? pipe_off_q[LATENCY-1] : '0;
  assign rdone   = rvalid & pipe_last_q[LATENCY-1];
  assign busy    = (state_q != S_IDLE);
  assign grant_i = busy & is_i_q;
  assign grant_d = busy & ~is_i_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_i_d  = is_i_q;
    blk_d   = blk_q;
    off_d   = off_q;
    wdat_d  = wdat_q;
    issue   = 1'b0;
    wr_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_req) begin
          state_d = S_READ;
          is_i_d  = 1'b1;
          blk_d   = i_addr[ADDR_W-1:OFF_W+1];
          off_d   = i_addr[OFF_W:1];
        end else if (d_req) begin
          state_d = d_wr ? S_WRITE : S_READ;
          is_i_d  = 1'b0;
          blk_d   = d_addr[ADDR_W-1:OFF_W+1];
          off_d   = d_addr[OFF_W:1];
          wdat_d  = d_wdata;
        end
      end
      S_READ: begin
        if (cnt_q < CNT_W'(BLOCK_WORDS)) begin
          issue = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
        // The transaction ends when its last word leaves the pipeline.
        if (rdone) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          wr_ack  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_i_q  <= 1'b0;
      blk_q   <= '0;
      off_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_i_q  <= is_i_d;
      blk_q   <= blk_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
    end
  end

  // Reset flushes the pipeline by clearing only its valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe_vld_q[i] <= 1'b0;
    end else begin
      pipe_vld_q[0] <= issue;
      for (int i = 1; i < LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // Stage 0 is a synchronous array read. Transactions never overlap, so a
  // read always sees every write that was acked before it.
  always_ff @(posedge clk) begin
    pipe_dat_q[0]  <= mem_q[{blk_q, issue_off}];
    pipe_off_q[0]  <= issue_off;
    pipe_last_q[0] <= issue_last;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_dat_q[i]  <= pipe_dat_q[i-1];
      pipe_off_q[i]  <= pipe_off_q[i-1];
      pipe_last_q[i] <= pipe_last_q[i-1];
    end
  end

  // Array contents survive reset. A write that coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_ack && !rst) mem_q[{blk_q, off_q}] <= wdat_q;
  end

endmodule

// File: tb/tb_fill_responder.sv
module tb_fill_responder;
  localparam int BW  = 8;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        grant_i, grant_d, busy, rvalid, rdone, wr_ack;
  logic [15:0] rdata;
  logic [2:0]  rword;

  int total = 0;
  int bad   = 0;

  // Reference memory, indexed by word address.
  logic [15:0] mem_m [int];
  logic [15:0] bases [4];

  fill_responder dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .grant_i(grant_i), .grant_d(grant_d), .busy(busy),
    .rdata(rdata), .rvalid(rvalid), .rword(rword), .rdone(rdone),
    .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The caller has already driven the request, with the DUT idle. The
  // following edge is E0. Cycles 1..BW+LAT+1 are sampled at the negedge.
  task automatic check_fill(input bit is_i, input logic [15:0] addr,
                            input int drop_at, input int rst_at);
    int base_w, ro, k, off;
    bit live, v, eb;
    logic [15:0] ed;
    base_w = (addr >> 1) & ~(BW - 1);
    ro     = (addr >> 1) % BW;
    @(posedge clk);
    for (int n = 1; n <= BW + LAT + 1; n++) begin
      @(negedge clk);
      live = (rst_at == 0) || (n <= rst_at);
      k    = n - 1 - LAT;
      v    = live && k >= 0 && k < BW;
      eb   = live && n <= BW + LAT;
`ifdef FILL_RESPONDER_CRIT_WORD_EN
      off  = (ro + k) % BW;
`else
      off  = k;
`endif
      chk($sformatf("fill%0h n%0d busy", addr, n), busy, eb);
      chk($sformatf("fill%0h n%0d grant_i", addr, n), grant_i, eb && is_i);
      chk($sformatf("fill%0h n%0d grant_d", addr, n), grant_d, eb && !is_i);
      chk($sformatf("fill%0h n%0d rvalid", addr, n), rvalid, v);
      chk($sformatf("fill%0h n%0d rdone", addr, n), rdone, v && k == BW - 1);
      chk($sformatf("fill%0h n%0d wr_ack", addr, n), wr_ack, 0);
      if (v) begin
        ed = mem_m.exists(base_w + off) ? mem_m[base_w + off] : 16'hxxxx;
        chk($sformatf("fill%0h n%0d rword", addr, n), rword, off);
        chk($sformatf("fill%0h n%0d rdata", addr, n), rdata, ed);
      end else begin
        chk($sformatf("fill%0h n%0d rdata0", addr, n), {rword, rdata}, 0);
      end
      if (n == drop_at || n == BW + LAT) begin
        if (is_i) i_req = 1'b0; else d_req = 1'b0;
      end
      if (n == rst_at) begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
      end
      if (rst_at > 0 && n == rst_at + 1) rst = 1'b0;
    end
  endtask

  task automatic check_write(input logic [15:0] addr, input logic [15:0] data);
    @(posedge clk);
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      chk($sformatf("wr%0h n%0d busy", addr, n), busy, n <= LAT);
      chk($sformatf("wr%0h n%0d grant_d", addr, n), grant_d, n <= LAT);
      chk($sformatf("wr%0h n%0d grant_i", addr, n), grant_i, 0);
      chk($sformatf("wr%0h n%0d wr_ack", addr, n), wr_ack, n == LAT);
      chk($sformatf("wr%0h n%0d rvalid", addr, n), rvalid, 0);
      if (n == LAT) begin
        mem_m[int'(addr >> 1)] = data;
        d_req = 1'b0;
      end
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    d_req = 1'b1; d_wr = 1'b1; d_addr = addr; d_wdata = data;
    check_write(addr, data);
  endtask

  task automatic do_fill(input bit is_i, input logic [15:0] addr,
                         input int drop_at, input int rst_at);
    if (is_i) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_wr = 1'b0; d_addr = addr; d_wdata = 16'h0;
    end
    check_fill(is_i, addr, drop_at, rst_at);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, blk;
    int op;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk($sformatf("idle n%0d", n),
          {grant_i, grant_d, busy, rvalid, rdone, wr_ack, rword, rdata}, 0);
    end

    // Load the blocks that are read back later.
    bases[0] = 16'h1000;
    bases[1] = 16'h2000;
    bases[2] = 16'($urandom_range(16'h3000, 16'hFFFF)) & 16'hFFF0;
    bases[3] = 16'($urandom_range(16'h3000, 16'hFFFF)) & 16'hFFF0;
    for (int k = 0; k < BW; k++) do_write(16'h1000 + 16'(2 * k), 16'hA000 + 16'(k));
    for (int b = 1; b < 4; b++)
      for (int k = 0; k < BW; k++) do_write(bases[b] + 16'(2 * k), 16'($urandom));

    // Basic I fill, then a D fill whose requested word is mid-block.
    do_fill(1'b1, 16'h1000, 0, 0);
    do_fill(1'b0, 16'h100A, 0, 0);

    // Contention: I is served first, then the held write is accepted.
    i_req = 1'b1; i_addr = 16'h1000;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2004; d_wdata = 16'hBEEF;
    check_fill(1'b1, 16'h1000, 0, 0);
    check_write(16'h2004, 16'hBEEF);
    chk("beef model", mem_m[int'(16'h2004 >> 1)], 16'hBEEF);
    do_fill(1'b0, 16'h2000, 0, 0);

    // Reset in cycle 7 of a fill, then a clean fill.
    do_fill(1'b1, 16'h1000, 0, 7);
    do_fill(1'b1, 16'h2000, 0, 0);

    // Request dropped in cycle 3: the fill still completes.
    do_fill(1'b1, 16'h1000, 3, 0);

    // Random mix of writes and fills on the loaded blocks. A random odd byte
    // address checks that bit 0 of the address is ignored.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      blk = bases[$urandom_range(0, 3)];
      a   = blk + 16'(2 * $urandom_range(0, BW - 1)) + 16'($urandom_range(0, 1));
      op  = $urandom_range(0, 2);
      if (op == 0) do_write(a, 16'($urandom));
      else do_fill(op == 1, a, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fill_responder.md
# fill_responder

Main-memory responder that serves the instruction and data caches. It arbitrates between an I-cache block-fill port and a D-cache port that carries block fills and single-word write-throughs. Storage is an internal word array behind a fixed-latency read pipeline, and fill data is streamed back one word per cycle. It is the memory end of the cache miss/fill protocol and sits below both cache instances inside the memory subsystem.

## Interface
Parameters:
- ADDR_W, 16, byte-address width; the word index is addr[ADDR_W-1:1].
- DATA_W, 16, word width.
- LATENCY, 4, cycles from word issue to word return; must be ≥1.
- BLOCK_WORDS, 8, words per cache block (16 B); must be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_req  in  1  I-cache fill request.
- i_addr  in  ADDR_W  I-cache miss address (byte).
- d_req  in  1  D-cache request.
- d_wr  in  1  D-cache request is a single-word write (1) or a block fill (0).
- d_addr  in  ADDR_W  D-cache address (byte).
- d_wdata  in  DATA_W  D-cache write data.
- grant_i  out  1  I-cache transaction in progress.
- grant_d  out  1  D-cache transaction in progress.
- busy  out  1  state ≠ IDLE.
- rdata  out  DATA_W  returned word; 0 whenever rvalid=0.
- rvalid  out  1  rdata/rword valid this cycle.
- rword  out  log2(BLOCK_WORDS)  word offset of rdata within its block.
- rdone  out  1  last word of a fill (coincident with final rvalid).
- wr_ack  out  1  single-cycle pulse when a write has been committed.

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE, sampled at a clock edge:
  - i_req=1 → READ for I. I-cache has fixed priority.
  - Else d_req=1 & d_wr=0 → READ for D.
  - Else d_req=1 & d_wr=1 → WRITE.
- On acceptance, the responder latches the requester, the block base (addr with low log2(BLOCK_WORDS)+1 bits cleared) and the word offset, plus the write data if writing.
- READ:
  - An issue counter runs 0..BLOCK_WORDS-1, issuing one word per cycle into a LATENCY-deep valid/data/offset pipeline.
  - Each word pops out LATENCY cycles after issue and drives rvalid, rdata and rword.
  - After the pipeline drains, the FSM returns to IDLE.
- WRITE:
  - A counter runs LATENCY cycles.
  - In the last cycle, wr_ack=1 and the array word is written at that clock edge.
  - The FSM then returns to IDLE.
- grant_i/grant_d are high throughout the accepted transaction and low in IDLE.
- Requesters hold req stable until rdone or wr_ack. Once a transaction is accepted, request and address changes are ignored until it completes.
- Reset during any state:
  - Pipeline is flushed; FSM goes to IDLE.
  - All outputs are 0 on the following cycle.
  - Any in-flight write is discarded.
  - Array contents are not cleared by rst.
- Array reads see all previously acked writes; no bypass is needed because transactions never overlap.

## Timing
- Reset values: grant_i=grant_d=busy=rvalid=rdone=wr_ack=0, rdata=0, rword=0.
- Cycle numbering: acceptance edge = E0; "cycle n" is the n-th cycle after E0.
- Fill:
  - Word k is issued in cycle 1+k.
  - It returns with rvalid in cycle 1+k+LATENCY.
  - rvalid is high for BLOCK_WORDS consecutive cycles.
  - rdone is in cycle BLOCK_WORDS+LATENCY (12 with the defaults).
  - busy/grant are high in cycles 1..BLOCK_WORDS+LATENCY; the FSM is IDLE the next cycle.
- Write: busy in cycles 1..LATENCY, wr_ack in cycle LATENCY, IDLE in cycle LATENCY+1.
- Back-to-back: a request held high is accepted at the first IDLE edge, giving a minimum one-cycle gap between transactions.
- Simultaneous i_req and d_req: I is served first. D is accepted at the first IDLE edge where i_req=0.
- Address arithmetic wraps modulo the array depth; block base + offset never crosses a block boundary.

## Configuration
- FILL_RESPONDER_CRIT_WORD_EN defined:
  - Fills return the requested word first.
  - Issue offset = (req_offset + k) mod BLOCK_WORDS, wrapping within the block.
  - rword reports the true offset.
- Undefined: fills always return offsets 0,1,…,BLOCK_WORDS-1 in order; req_offset is ignored.
- Cycle counts are identical in both builds.

## Test plan
- Reset then idle: rst for 2 cycles, no requests → all outputs 0, busy=0 for 20 cycles.
- Basic fill: array word at byte 0x1000+2k preloaded with 0xA000+k; i_req, i_addr=0x1000 → rvalid cycles 5–12, rdata 0xA000..0xA007, rword 0..7, rdone only in cycle 12, grant_i high in cycles 1–12.
- Critical word: FILL_RESPONDER_CRIT_WORD_EN build, d fill at d_addr=0x100A → rword sequence 5,6,7,0,1,2,3,4 with matching data; same cycles as the basic fill.
- Contention then write: i_req and d_req (write 0xBEEF to 0x2004) asserted in the same cycle → I fill completes first; write accepted next IDLE edge; wr_ack exactly 4 cycles later; a following d fill of 0x2000 returns 0xBEEF at rword=2.
- Reset mid-fill: rst asserted in cycle 7 of a fill → rvalid=0 and busy=0 from cycle 8 on; no rdone; a new fill afterward returns correct data.
- Dropped request: i_req deasserted in cycle 3 → fill still delivers all 8 words and rdone.
